// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: request side in, status/result side out.
// No latency of its own; pure wiring.
// No backpressure: start is sampled only when the engine is idle or finishing.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    // Requester drives operands and start, observes status/result.
    modport master (
        output start, m, a, b,
        input  busy, done, sum, c_out, overflow
    );

    // Engine side.
    modport slave (
        input  start, m, a, b,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first.
// Latency: done pulses N=WIDTH/DIGIT cycles after busy rises.
// No backpressure: start is ignored while busy; start during the done cycle chains with no gap.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic          clk,
    input  logic          rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT:0]   dsum;
    logic             cin_msb;

    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.start;
                if (bus.start) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                last = (k == CW'(N - 1));
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                accept = bus.start;
                state_nxt = bus.start ? CALC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One digit of the ripple add; the carry into the digit MSB is recovered
    // from the MSB sum bit so it also works for DIGIT=1.
    always_comb begin
        da      = op_a[int'(k) * DIGIT +: DIGIT];
        db      = op_b[int'(k) * DIGIT +: DIGIT];
        dsum    = {1'b0, da} + {1'b0, db} + (DIGIT + 1)'(carry);
        cin_msb = da[DIGIT-1] ^ db[DIGIT-1] ^ dsum[DIGIT-1];
        acc_nxt = acc;
        acc_nxt[int'(k) * DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    end

    // Operand capture, digit iteration, and result publication on the last digit.
    // Subtraction is a + ~b + 1, so b is inverted and the carry seeded with m.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            k       <= '0;
            acc     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.m}};
            carry <= bus.m;
            k     <= '0;
        end else if (state == CALC) begin
            acc   <= acc_nxt;
            carry <= dsum[DIGIT];
            if (last) begin
                sum_r   <= acc_nxt;
                c_out_r <= dsum[DIGIT];
                ovf_r   <= cin_msb ^ dsum[DIGIT];
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.sum      = sum_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ovf_r;
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2: bits processed per clock cycle; WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port m  input  1  mode: 0 = a+b, 1 = a-b.
REQ-007 The block SHALL have port a  input  WIDTH  first operand, two's complement or unsigned.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port busy  output  1  operation in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-011 The block SHALL have port sum  output  WIDTH  result, a±b modulo 2^WIDTH.
REQ-012 The block SHALL have port c_out  output  1  carry out of MSB (in subtract mode 1 = no borrow).
REQ-013 The block SHALL have port overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE, with N = WIDTH/DIGIT.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: latch a, b XOR {WIDTH{m}}, initial carry = m, clear digit counter, enter CALC.
REQ-016 In CALC, each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1 down to k*DIGIT, LSB digit first) of both latched operands plus the carry, store the DIGIT result bits in an internal register, update the carry, and increment k.
REQ-017 After the N-th CALC cycle the FSM SHALL enter DONE for exactly one cycle, then return to IDLE unless a new start is accepted.
REQ-018 busy SHALL be 1 exactly while in CALC; done SHALL be 1 exactly while in DONE.
REQ-019 Latency: start accepted at edge E0 -> done high for the cycle after edge E(N+1)... precisely, done SHALL be high in the cycle following edge EN, i.e. N cycles after busy rises.
REQ-020 sum, c_out, overflow SHALL update only on the edge entering DONE and SHALL then hold until the next entry into DONE; they SHALL NOT show partial results during CALC.
REQ-021 start while busy=1 SHALL be ignored; changes on a, b, m during CALC SHALL have no effect.
REQ-022 start accepted in DONE SHALL still produce that cycle's done pulse and SHALL begin the new operation with no idle cycle.
REQ-023 DIGIT = WIDTH SHALL be supported: N = 1, single CALC cycle.
REQ-024 overflow SHALL be computed from the carry into and out of bit WIDTH-1 of the final digit.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force state IDLE and busy, done, sum, c_out, overflow, internal registers and counter to 0.
REQ-026 rst asserted during CALC or DONE SHALL discard the pending operation; no done pulse SHALL follow release of rst.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 WIDTH=4, DIGIT=1: a=3, b=5, m=0, start pulse -> busy 4 cycles, then done with sum=1000, c_out=0, overflow=1.
REQ-029 WIDTH=4, DIGIT=1: a=7, b=1, m=1 -> sum=0110, c_out=1, overflow=0; a=1000, b=0001, m=1 -> sum=0111, c_out=1, overflow=1.
REQ-030 WIDTH=4, DIGIT=1: a=0, b=1, m=1 -> sum=1111, c_out=0, overflow=0.
REQ-031 WIDTH=8, DIGIT=4: a=0x7F, b=0x01, m=0 -> busy exactly 2 cycles, sum=0x80, c_out=0, overflow=1; start held high throughout -> back-to-back operations, done every 3 cycles, busy low only in DONE.
REQ-032 start pulsed again mid-CALC with different operands -> ignored, original result reported; rst pulsed mid-CALC -> all outputs 0 immediately, no done afterwards.
